// File: rtl/serializer_if.sv
// serializer_if: parallel handshake in, serial line and word-done strobe out
interface serializer_if;
    logic [9:0] Data_In;
    logic       Data_Valid;
    logic       Data_Ready;
    logic       PRBS_Mode;
    logic       Serial;
    logic       Data_Sent;
    modport master (output Data_In, Data_Valid, PRBS_Mode, input Data_Ready, Serial, Data_Sent);
    modport slave (input Data_In, Data_Valid, PRBS_Mode, output Data_Ready, Serial, Data_Sent);
endinterface

// File: rtl/serializer.sv
// serializer: 10-bit LSB-first serializer with K28.5 idle fill; PRBS7 test mode when SERIALIZER_PRBS_EN is defined
module serializer (
    input logic         data_clock,
    input logic         Reset,
    serializer_if.slave bus
);
    localparam logic [9:0] COMMA = 10'b0101111100;
`ifdef SERIALIZER_PRBS_EN
    typedef enum logic [1:0] {IDLE, DATA, PRBS} state_t;
    logic [6:0] lfsr_q, lfsr_d;
`else
    typedef enum logic {IDLE, DATA} state_t;
    logic unused_prbs_mode;
    assign unused_prbs_mode = bus.PRBS_Mode;
`endif
    state_t     state_q, state_d;
    logic [9:0] sreg_q, sreg_d, hold_q, hold_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       hold_valid_q, hold_valid_d;
    logic       boundary, ready, accept;
    assign boundary = bit_cnt_q == 4'd9;
    assign accept = bus.Data_Valid && ready;
    always_ff @(posedge data_clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            sreg_q <= '0;
            bit_cnt_q <= 4'd9;
            hold_valid_q <= 1'b0;
`ifdef SERIALIZER_PRBS_EN
            lfsr_q <= 7'h7F;
`endif
        end else begin
            state_q <= state_d;
            sreg_q <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            hold_valid_q <= hold_valid_d;
`ifdef SERIALIZER_PRBS_EN
            lfsr_q <= lfsr_d;
`endif
        end
        hold_q <= hold_d;
    end
    // the load at a boundary always takes the pre-edge hold, never Data_In directly
    always_comb begin
        state_d = boundary ? (hold_valid_q ? DATA : IDLE) : state_q;
`ifdef SERIALIZER_PRBS_EN
        if (boundary && bus.PRBS_Mode) state_d = PRBS;
`endif
        bit_cnt_d = boundary ? 4'd0 : bit_cnt_q + 4'd1;
        sreg_d = !boundary ? {1'b0, sreg_q[9:1]} : hold_valid_q ? hold_q : COMMA;
        hold_d = accept ? bus.Data_In : hold_q;
        hold_valid_d = accept || (hold_valid_q && !(boundary && state_d == DATA));
`ifdef SERIALIZER_PRBS_EN
        lfsr_d = lfsr_q;
        if (state_d == PRBS) begin
            sreg_d = {9'd0, lfsr_q[6]};
            lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
`endif
    end
    always_comb begin
        ready = !hold_valid_q && Reset;
`ifdef SERIALIZER_PRBS_EN
        if (state_q == PRBS) ready = 1'b0;
`endif
        bus.Data_Ready = ready;
        bus.Data_Sent = state_q == DATA && boundary;
        bus.Serial = sreg_q[0];
    end
endmodule
